// File: rtl/catch_pkg.sv
// Shared definitions for the catch game: sequencer states, player encoding
// and ball end-position helper.
package catch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    FLIGHT   = 3'd2,
    WINDOW   = 3'd3,
    POINT    = 3'd4,
    GAMEOVER = 3'd5
  } state_e;

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  localparam int unsigned FLIGHT_TICKS_DEF = 8;

  // P1 owns position 0, P2 owns the far end of the track.
  function automatic logic [3:0] end_pos(input int unsigned flight_ticks, input logic player);
    logic [3:0] pos;
    if (player == PLAYER_P2) begin
      pos = 4'(flight_ticks - 1);
    end else begin
      pos = 4'd0;
    end
    return pos;
  endfunction

endpackage

// File: rtl/catch_btn_edge.sv
// Rising-edge pulse generator: pulse is high in the cycle the level first
// samples high, so the consumer acts on that same clock edge.
module catch_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev_r;

  // history of the level from the previous clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level;
    end
  end

  assign pulse = level & ~prev_r;

endmodule

// File: rtl/catch_rally_ctrl.sv
// Catch game sequencer: serve, ball flight, catch window, scoring and game
// over, all timed by the timebase tick.
module catch_rally_ctrl
  import catch_pkg::*;
#(
  parameter int unsigned FLIGHT_TICKS = FLIGHT_TICKS_DEF,
  parameter int unsigned WINDOW_TICKS = 2,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned MAX_SCORE    = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic               btn_p1,
  input  logic               btn_p2,
  output logic [3:0]         ball_pos,
  output logic               holder,
  output logic               window_led,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               game_over,
  output logic               winner
);

  localparam logic [3:0]         P1_END    = end_pos(FLIGHT_TICKS, PLAYER_P1);
  localparam logic [3:0]         P2_END    = end_pos(FLIGHT_TICKS, PLAYER_P2);
  localparam int unsigned        CNT_W     = $clog2(WINDOW_TICKS + 1);
  localparam logic [CNT_W-1:0]   WIN_LAST  = CNT_W'(WINDOW_TICKS - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  logic p1_press_s, p2_press_s, start_press_s;

  catch_btn_edge u_edge_p1 (.clk(clk), .rst(rst), .level(btn_p1), .pulse(p1_press_s));
  catch_btn_edge u_edge_p2 (.clk(clk), .rst(rst), .level(btn_p2), .pulse(p2_press_s));
  catch_btn_edge u_edge_st (.clk(clk), .rst(rst), .level(start),  .pulse(start_press_s));

  state_e             state_r;
  logic [3:0]         ball_pos_r;
  logic               holder_r;
  logic               window_led_r;
  logic [SCORE_W-1:0] score_p1_r, score_p2_r;
  logic               game_over_r;
  logic               winner_r;
  logic [CNT_W-1:0]   win_cnt_r;

  logic               thrower_press_s, receiver_press_s;
  logic [3:0]         recv_end_s, next_pos_s;
  logic [SCORE_W-1:0] thrower_score_s, new_score_s;

  // role-relative view of buttons, positions and the thrower's score
  always_comb begin
    thrower_press_s  = 1'b0;
    receiver_press_s = 1'b0;
    recv_end_s       = P2_END;
    next_pos_s       = ball_pos_r;
    thrower_score_s  = score_p1_r;
    if (holder_r == PLAYER_P2) begin
      thrower_press_s  = p2_press_s;
      receiver_press_s = p1_press_s;
      recv_end_s       = P1_END;
      next_pos_s       = ball_pos_r - 4'd1;
      thrower_score_s  = score_p2_r;
    end else begin
      thrower_press_s  = p1_press_s;
      receiver_press_s = p2_press_s;
      recv_end_s       = P2_END;
      next_pos_s       = ball_pos_r + 4'd1;
      thrower_score_s  = score_p1_r;
    end
    if (thrower_score_s == SCORE_MAX) begin
      new_score_s = thrower_score_s;
    end else begin
      new_score_s = thrower_score_s + SCORE_ONE;
    end
  end

  // game state machine with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      ball_pos_r   <= 4'd0;
      holder_r     <= PLAYER_P1;
      window_led_r <= 1'b0;
      score_p1_r   <= '0;
      score_p2_r   <= '0;
      game_over_r  <= 1'b0;
      winner_r     <= 1'b0;
      win_cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE, GAMEOVER: begin
          if (start_press_s) begin
            state_r      <= SERVE;
            ball_pos_r   <= P1_END;
            holder_r     <= PLAYER_P1;
            window_led_r <= 1'b0;
            score_p1_r   <= '0;
            score_p2_r   <= '0;
            game_over_r  <= 1'b0;
            winner_r     <= 1'b0;
          end
        end
        SERVE: begin
          if (thrower_press_s) begin
            state_r <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (tick) begin
            ball_pos_r <= next_pos_s;
            if (next_pos_s == recv_end_s) begin
              state_r      <= WINDOW;
              win_cnt_r    <= '0;
              window_led_r <= 1'b1;
            end
          end
        end
        WINDOW: begin
          // a catch beats an expiring tick in the same cycle
          if (receiver_press_s) begin
            holder_r     <= ~holder_r;
            state_r      <= FLIGHT;
            window_led_r <= 1'b0;
          end else if (tick) begin
            if (win_cnt_r == WIN_LAST) begin
              state_r      <= POINT;
              window_led_r <= 1'b0;
            end else begin
              win_cnt_r <= win_cnt_r + CNT_ONE;
            end
          end
        end
        POINT: begin
          if (holder_r == PLAYER_P2) begin
            score_p2_r <= new_score_s;
          end else begin
            score_p1_r <= new_score_s;
          end
          if (new_score_s == SCORE_MAX) begin
            state_r     <= GAMEOVER;
            game_over_r <= 1'b1;
            winner_r    <= holder_r;
          end else begin
            state_r    <= SERVE;
            holder_r   <= ~holder_r;
            ball_pos_r <= recv_end_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ball_pos   = ball_pos_r;
  assign holder     = holder_r;
  assign window_led = window_led_r;
  assign score_p1   = score_p1_r;
  assign score_p2   = score_p2_r;
  assign game_over  = game_over_r;
  assign winner     = winner_r;

endmodule
